// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl -- round sequencer for the AES-128 encryption datapath.
//
// Walks the step units through ARK(0), then for each round SUB -> SHIFT ->
// [MIX, skipped in the final round] -> ARK, using per-unit enable/done
// handshakes. Tells the top-level state register when to load plaintext and
// which step output to capture.
//
// Parameters:
//   NR       number of rounds (1..15)
//   TIMEOUT  max cycles a step may wait for its done (timeout build only)
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   start                          begin an encryption (sampled in IDLE only)
//   busy                           high in every state except IDLE
//   done                           one-cycle completion pulse
//   load                           one-cycle plaintext load strobe
//   round[3:0]                     current round index 0..NR
//   sub_en/shift_en/mix_en/ark_en  registered step enables
//   sub_done/.../ark_done          step completion flags
//   state_we                       state register write strobe
//   state_sel[1:0]                 write-back source 0 SUB,1 SHIFT,2 MIX,3 ARK
//   err                            sticky step-timeout flag
//
// Build option: define AES_ROUND_CTRL_TIMEOUT_EN to abort a step whose done
// stays low for TIMEOUT cycles; otherwise steps wait forever and err is 0.
`timescale 1ns/1ps

module aes_round_ctrl #(
  parameter int NR      = 10,
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       load,
  output logic [3:0] round,
  output logic       sub_en,
  output logic       shift_en,
  output logic       mix_en,
  output logic       ark_en,
  input  logic       sub_done,
  input  logic       shift_done,
  input  logic       mix_done,
  input  logic       ark_done,
  output logic       state_we,
  output logic [1:0] state_sel,
  output logic       err
);

  if (NR < 1 || NR > 15 || TIMEOUT < 1) begin : g_param_check
    $error("aes_round_ctrl: NR must be 1..15 and TIMEOUT >= 1");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SUB   = 3'd1,
    SHIFT = 3'd2,
    MIX   = 3'd3,
    ARK   = 3'd4,
    FIN   = 3'd5
  } state_t;

  localparam logic [3:0] LAST = 4'(NR);

  state_t     state, state_n;
  logic       step_done;
  logic [1:0] step_code;

`ifdef AES_ROUND_CTRL_TIMEOUT_EN
  localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);
  logic [TCNT_W-1:0] tcnt;
  logic              in_step;
  logic              timeout_hit;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    load      = 1'b0;
    done      = 1'b0;
    step_done = 1'b0;
    step_code = 2'd0;
`ifdef AES_ROUND_CTRL_TIMEOUT_EN
    in_step     = 1'b0;
    timeout_hit = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = ARK;
        end
      end
      SUB: begin
        step_code = 2'd0;
        step_done = sub_en & sub_done;
        if (step_done) state_n = SHIFT;
      end
      SHIFT: begin
        step_code = 2'd1;
        step_done = shift_en & shift_done;
        if (step_done) state_n = (round == LAST) ? ARK : MIX;
      end
      MIX: begin
        step_code = 2'd2;
        step_done = mix_en & mix_done;
        if (step_done) state_n = ARK;
      end
      ARK: begin
        step_code = 2'd3;
        step_done = ark_en & ark_done;
        if (step_done) state_n = (round == LAST) ? FIN : SUB;
      end
      FIN: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
`ifdef AES_ROUND_CTRL_TIMEOUT_EN
    in_step = (state == SUB) || (state == SHIFT) || (state == MIX) || (state == ARK);
    if (in_step && !step_done && tcnt == TCNT_LAST) begin
      timeout_hit = 1'b1;
      state_n     = IDLE;
    end
`endif
    // A step finishing in the reset cycle is abandoned: no strobes escape.
    if (rst) begin
      load      = 1'b0;
      done      = 1'b0;
      step_done = 1'b0;
    end
  end

  assign busy      = (state != IDLE);
  assign state_we  = step_done;
  assign state_sel = step_done ? step_code : 2'd0;

  // Enables are registered from the next state so each is high for exactly
  // the cycles the FSM spends in the matching step state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sub_en   <= 1'b0;
      shift_en <= 1'b0;
      mix_en   <= 1'b0;
      ark_en   <= 1'b0;
    end else begin
      sub_en   <= (state_n == SUB);
      shift_en <= (state_n == SHIFT);
      mix_en   <= (state_n == MIX);
      ark_en   <= (state_n == ARK);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                          round <= '0;
    else if (state == IDLE && start)  round <= '0;
    else if (state == ARK && step_done && round != LAST)
                                      round <= round + 4'd1;
  end

`ifdef AES_ROUND_CTRL_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst || state_n != state)     tcnt <= '0;
    else if (in_step && !step_done)  tcnt <= tcnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)                          err <= 1'b0;
    else if (state == IDLE && start)  err <= 1'b0;
    else if (timeout_hit)             err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule
